updown_counter_param: RTL and testbench
=======================================

// Module: updown_counter_param
// PURPOSE
//   Parametrised synchronous up/down counter with parallel load and synchronous clear. Used as the
//   next-generation LIFO stack pointer and as a general modulo counter.
//   Adds over the fixed 5-bit counter: width and modulus parameters, wrap or saturate mode,
//   registered carry/borrow pulses, terminal-count flags and asynchronous active-low reset.
// PARAMETERS
//   WIDTH     5    counter width in bits (2..16)
//   MAX_VAL   31   terminal count; counts span 0..MAX_VAL; must satisfy 1 <= MAX_VAL <= 2**WIDTH-1
//   SATURATE  0    0 = wrap modulo MAX_VAL+1; 1 = hold at 0 / MAX_VAL
// PORTS
//   Clk       in   1      rising-edge clock
//   Rst_n     in   1      asynchronous active-low reset
//   Clr       in   1      synchronous clear to 0
//   Load      in   1      synchronous parallel load of Load_val
//   Load_val  in   WIDTH  value to load
//   E         in   1      count enable
//   D         in   1      direction: 1 = up (increment), 0 = down (decrement)
//   Out       out  WIDTH  current count
//   O_Carry   out  1      1-cycle pulse: up-step attempted from MAX_VAL
//   O_Borrow  out  1      1-cycle pulse: down-step attempted from 0
//   O_Max     out  1      Out == MAX_VAL (combinational from Out)
//   O_Zero    out  1      Out == 0 (combinational from Out)
// BEHAVIOUR
//   - Rst_n low, at any time including mid-count, asynchronously forces Out = 0, O_Carry = 0 and
//     O_Borrow = 0. O_Zero reads 1 and O_Max reads 0.
//   - Per rising Clk edge, priority is Clr > Load > (E count) > hold:
//       Clr=1          : Out <= 0
//       Load=1         : Out <= min(Load_val, MAX_VAL); out-of-range values clamp, never exceed MAX_VAL
//       E=1, D=1       : Out < MAX_VAL  -> Out+1
//                        Out == MAX_VAL -> 0 if SATURATE=0, hold if SATURATE=1; O_Carry <= 1
//       E=1, D=0       : Out > 0        -> Out-1
//                        Out == 0       -> MAX_VAL if SATURATE=0, hold if SATURATE=1; O_Borrow <= 1
//       E=0            : hold
//   - O_Carry and O_Borrow are registered. Each is high for exactly the one cycle after the
//     boundary step, then returns to 0. They are never both 1.
//   - A Clr or Load in the same cycle as E suppresses the count and both pulses.
//   - Latency: Out reflects an operation one cycle after the sampling edge. O_Max and O_Zero
//     follow Out with no extra delay.
//   - Arithmetic: internal compare/add is WIDTH+1 bits, so MAX_VAL = 2**WIDTH-1 wraps cleanly;
//     Out never leaves 0..MAX_VAL.
//   - Continuous E with D toggling every cycle alternates +1/-1 with no lost steps.
//   - An illegal MAX_VAL is flagged at elaboration ($error in a generate check).
// TESTING
//   1. Rst_n=0 asserted mid-count at Out=7 -> Out=0, O_Zero=1 immediately, before the next Clk edge.
//   2. WIDTH=5, MAX_VAL=31, SATURATE=0, E=1, D=1 for 33 cycles from 0
//      -> Out 0..31,0,1; O_Carry high only in the cycle after 31->0.
//   3. MAX_VAL=9, SATURATE=0, D=0 from 0 -> Out=9, O_Borrow=1 for one cycle;
//      Load_val=12 -> Out=9 (clamped), O_Max=1.
//   4. SATURATE=1, MAX_VAL=9: up from 9 -> Out stays 9 with O_Carry=1;
//      down from 0 -> stays 0 with O_Borrow=1.
//   5. Priority: Clr=1, Load=1, E=1, Load_val=5 at Out=3 -> Out=0;
//      then Load=1, E=1, D=1, Load_val=5 -> Out=5, O_Carry=0.
//   6. E=0 with D toggling for 10 cycles at Out=4 -> Out stays 4, no pulses;
//      random E/D/Load for 10k cycles vs. reference model -> no mismatch.

Source files
------------

// File: rtl/updown_counter_param.sv
// ---------------------------------------------------------------------------
// updown_counter_param
//   Parametrised synchronous up/down counter with parallel load and
//   synchronous clear. Counts span 0..MAX_VAL and either wrap modulo
//   MAX_VAL+1 (SATURATE=0) or hold at the boundary (SATURATE=1).
//   Serves as a LIFO stack pointer or as a general modulo counter.
//
// Parameters
//   WIDTH     counter width in bits (2..16)
//   MAX_VAL   terminal count, 1 <= MAX_VAL <= 2**WIDTH-1
//   SATURATE  0 = wrap, 1 = hold at 0 / MAX_VAL
//
// Ports
//   Clk       in   1      rising-edge clock
//   Rst_n     in   1      asynchronous active-low reset
//   Clr       in   1      synchronous clear to 0 (highest priority)
//   Load      in   1      synchronous load of min(Load_val, MAX_VAL)
//   Load_val  in   WIDTH  value to load
//   E         in   1      count enable
//   D         in   1      direction: 1 = up, 0 = down
//   Out       out  WIDTH  current count
//   O_Carry   out  1      registered pulse: up-step attempted from MAX_VAL
//   O_Borrow  out  1      registered pulse: down-step attempted from 0
//   O_Max     out  1      Out == MAX_VAL
//   O_Zero    out  1      Out == 0
// ---------------------------------------------------------------------------
module updown_counter_param #(
    parameter int WIDTH    = 5,
    parameter int MAX_VAL  = 31,
    parameter int SATURATE = 0
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Clr,
    input  logic             Load,
    input  logic [WIDTH-1:0] Load_val,
    input  logic             E,
    input  logic             D,
    output logic [WIDTH-1:0] Out,
    output logic             O_Carry,
    output logic             O_Borrow,
    output logic             O_Max,
    output logic             O_Zero
);

    // Compares and the increment are done one bit wider than the counter so
    // MAX_VAL = 2**WIDTH-1 and out-of-range load values are handled exactly.
    localparam logic [WIDTH:0]   LP_MAX_EXT = (WIDTH + 1)'(MAX_VAL);
    localparam logic [WIDTH:0]   LP_ONE_EXT = (WIDTH + 1)'(1);
    localparam logic [WIDTH-1:0] LP_MAX     = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] LP_ONE     = WIDTH'(1);

    if ((WIDTH < 2) || (WIDTH > 16) || (MAX_VAL < 1) ||
        (MAX_VAL > (2 ** WIDTH) - 1)) begin : g_bad_param
        $error("updown_counter_param: illegal WIDTH=%0d / MAX_VAL=%0d",
               WIDTH, MAX_VAL);
    end

    logic [WIDTH-1:0] r_cnt;
    logic             r_carry;
    logic             r_borrow;

    logic [WIDTH:0]   w_cnt_ext;
    logic [WIDTH:0]   w_inc_ext;
    logic [WIDTH:0]   w_load_ext;
    logic [WIDTH-1:0] w_load_clamped;
    logic             w_at_max;
    logic             w_at_zero;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic             w_carry_nxt;
    logic             w_borrow_nxt;

    assign w_cnt_ext      = {1'b0, r_cnt};
    assign w_inc_ext      = w_cnt_ext + LP_ONE_EXT;
    assign w_load_ext     = {1'b0, Load_val};
    assign w_load_clamped = (w_load_ext > LP_MAX_EXT) ? LP_MAX : Load_val;
    assign w_at_max       = (w_cnt_ext == LP_MAX_EXT);
    assign w_at_zero      = (r_cnt == '0);

    // Priority Clr > Load > count > hold. Clr and Load also kill the pulses.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        w_cnt_nxt    = r_cnt;
        w_carry_nxt  = 1'b0;
        w_borrow_nxt = 1'b0;
        if (Clr) begin
            w_cnt_nxt = '0;
        end else if (Load) begin
            w_cnt_nxt = w_load_clamped;
        end else if (E) begin
            if (D) begin
                if (w_at_max) begin
                    w_carry_nxt = 1'b1;
                    w_cnt_nxt   = (SATURATE != 0) ? r_cnt : '0;
                end else begin
                    w_cnt_nxt = w_inc_ext[WIDTH-1:0];
                end
            end else begin
                if (w_at_zero) begin
                    w_borrow_nxt = 1'b1;
                    w_cnt_nxt    = (SATURATE != 0) ? r_cnt : LP_MAX;
                end else begin
                    w_cnt_nxt = r_cnt - LP_ONE;
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values, independent of statement order.
        if (!Rst_n) begin
            r_cnt    <= '0;
            r_carry  <= 1'b0;
            r_borrow <= 1'b0;
        end else begin
            r_cnt    <= w_cnt_nxt;
            r_carry  <= w_carry_nxt;
            r_borrow <= w_borrow_nxt;
        end
    end

    assign Out      = r_cnt;
    assign O_Carry  = r_carry;
    assign O_Borrow = r_borrow;
    assign O_Max    = (r_cnt == LP_MAX);
    assign O_Zero   = (r_cnt == '0);

endmodule

// File: tb/tb_updown_counter_param.sv
// ---------------------------------------------------------------------------
// tb_updown_counter_param
//   Three instances share one stimulus stream:
//     u_a : WIDTH=5, MAX_VAL=31, wrap
//     u_b : WIDTH=5, MAX_VAL=9,  wrap
//     u_c : WIDTH=5, MAX_VAL=9,  saturate
//   Directed vectors with hand-computed expectations, followed by a random
//   run compared against a small behavioural model of each instance.
// ---------------------------------------------------------------------------
module tb_updown_counter_param;

    logic       Clk;
    logic       Rst_n;
    logic       Clr;
    logic       Load;
    logic [4:0] Load_val;
    logic       E;
    logic       D;

    logic [4:0] a_out, b_out, c_out;
    logic       a_carry, b_carry, c_carry;
    logic       a_borrow, b_borrow, c_borrow;
    logic       a_max, b_max, c_max;
    logic       a_zero, b_zero, c_zero;

    int n_checks = 0;
    int n_fail   = 0;

    updown_counter_param #(.WIDTH(5), .MAX_VAL(31), .SATURATE(0)) u_a (
        .Clk(Clk), .Rst_n(Rst_n), .Clr(Clr), .Load(Load), .Load_val(Load_val),
        .E(E), .D(D), .Out(a_out), .O_Carry(a_carry), .O_Borrow(a_borrow),
        .O_Max(a_max), .O_Zero(a_zero)
    );

    updown_counter_param #(.WIDTH(5), .MAX_VAL(9), .SATURATE(0)) u_b (
        .Clk(Clk), .Rst_n(Rst_n), .Clr(Clr), .Load(Load), .Load_val(Load_val),
        .E(E), .D(D), .Out(b_out), .O_Carry(b_carry), .O_Borrow(b_borrow),
        .O_Max(b_max), .O_Zero(b_zero)
    );

    updown_counter_param #(.WIDTH(5), .MAX_VAL(9), .SATURATE(1)) u_c (
        .Clk(Clk), .Rst_n(Rst_n), .Clr(Clr), .Load(Load), .Load_val(Load_val),
        .E(E), .D(D), .Out(c_out), .O_Carry(c_carry), .O_Borrow(c_borrow),
        .O_Max(c_max), .O_Zero(c_zero)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Advance one clock and sample 1 ns after the rising edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic clr, input logic load, input logic [4:0] lv,
                         input logic e, input logic d);
        Clr      = clr;
        Load     = load;
        Load_val = lv;
        E        = e;
        D        = d;
    endtask

    // Behavioural model: index 0 = u_a, 1 = u_b, 2 = u_c.
    int m_cnt    [3];
    bit m_carry  [3];
    bit m_borrow [3];
    int m_max    [3] = '{31, 9, 9};
    bit m_sat    [3] = '{1'b0, 1'b0, 1'b1};

    task automatic model_step(input int k, input bit clr, input bit load,
                              input int lv, input bit e, input bit d);
        m_carry[k]  = 1'b0;
        m_borrow[k] = 1'b0;
        if (clr)
            m_cnt[k] = 0;
        else if (load)
            m_cnt[k] = (lv > m_max[k]) ? m_max[k] : lv;
        else if (e && d) begin
            if (m_cnt[k] == m_max[k]) begin
                m_carry[k] = 1'b1;
                if (!m_sat[k]) m_cnt[k] = 0;
            end else
                m_cnt[k] = m_cnt[k] + 1;
        end else if (e) begin
            if (m_cnt[k] == 0) begin
                m_borrow[k] = 1'b1;
                if (!m_sat[k]) m_cnt[k] = m_max[k];
            end else
                m_cnt[k] = m_cnt[k] - 1;
        end
    endtask

    function automatic logic [31:0] model_pack(input int k);
        return {23'b0, 5'(m_cnt[k]), m_carry[k], m_borrow[k],
                m_cnt[k] == m_max[k], m_cnt[k] == 0};
    endfunction

    initial begin
        Rst_n = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        #2;
        // Reset state
        check("rst_out",    32'(a_out),    32'd0);
        check("rst_zero",   32'(a_zero),   32'd1);
        check("rst_max",    32'(a_max),    32'd0);
        check("rst_carry",  32'(a_carry),  32'd0);
        check("rst_borrow", 32'(a_borrow), 32'd0);
        @(negedge Clk);
        Rst_n = 1'b1;

        // Asynchronous reset in the middle of counting at Out=7
        drive(1'b0, 1'b1, 5'd7, 1'b0, 1'b0);
        tick();
        check("load7", 32'(a_out), 32'd7);
        drive(1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
        #2 Rst_n = 1'b0;
        #1;
        check("async_rst_out",  32'(a_out),  32'd0);
        check("async_rst_zero", 32'(a_zero), 32'd1);
        #1 Rst_n = 1'b1;
        drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        check("after_rst_hold", 32'(a_out), 32'd0);

        // Count up 33 cycles from 0 on all instances
        drive(1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
        for (int i = 1; i <= 33; i++) begin
            tick();
            check($sformatf("up_a_out_%0d", i),   32'(a_out),   32'(i % 32));
            check($sformatf("up_a_carry_%0d", i), 32'(a_carry), 32'(i == 32));
            check($sformatf("up_a_max_%0d", i),   32'(a_max),   32'(i == 31));
        end
        check("up_b_out",   32'(b_out),   32'd3);
        check("up_c_out",   32'(c_out),   32'd9);
        check("up_c_carry", 32'(c_carry), 32'd1);

        // Clear, then one down-step from 0
        drive(1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        check("clr_a", 32'(a_out), 32'd0);
        check("clr_b", 32'(b_out), 32'd0);
        drive(1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        tick();
        check("dn_a_out",    32'(a_out),    32'd31);
        check("dn_a_borrow", 32'(a_borrow), 32'd1);
        check("dn_b_out",    32'(b_out),    32'd9);
        check("dn_b_borrow", 32'(b_borrow), 32'd1);
        check("dn_b_max",    32'(b_max),    32'd1);
        check("dn_c_out",    32'(c_out),    32'd0);
        check("dn_c_borrow", 32'(c_borrow), 32'd1);
        drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        check("borrow_end_b", 32'(b_borrow), 32'd0);
        check("borrow_end_c", 32'(c_borrow), 32'd0);
        check("hold_b",       32'(b_out),    32'd9);

        // Load out-of-range value clamps to MAX_VAL
        drive(1'b0, 1'b1, 5'd12, 1'b0, 1'b0);
        tick();
        check("ld12_a",     32'(a_out), 32'd12);
        check("ld12_b",     32'(b_out), 32'd9);
        check("ld12_b_max", 32'(b_max), 32'd1);
        check("ld12_c",     32'(c_out), 32'd9);

        // Saturating up from MAX holds with a carry pulse
        drive(1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
        tick();
        check("sat_up_c_out",   32'(c_out),   32'd9);
        check("sat_up_c_carry", 32'(c_carry), 32'd1);
        check("wrap_up_b_out",  32'(b_out),   32'd0);
        check("wrap_up_b_cy",   32'(b_carry), 32'd1);
        check("up_a_13",        32'(a_out),   32'd13);
        check("no_carry_a",     32'(a_carry), 32'd0);

        // Saturating down from 0 holds with a borrow pulse
        drive(1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        tick();
        check("sat_dn_c_out",    32'(c_out),    32'd0);
        check("sat_dn_c_borrow", 32'(c_borrow), 32'd1);
        check("sat_dn_c_zero",   32'(c_zero),   32'd1);
        drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        check("sat_dn_c_pulse_end", 32'(c_borrow), 32'd0);

        // Priority: Clr beats Load beats count
        drive(1'b0, 1'b1, 5'd3, 1'b0, 1'b0);
        tick();
        check("ld3", 32'(a_out), 32'd3);
        drive(1'b1, 1'b1, 5'd5, 1'b1, 1'b1);
        tick();
        check("prio_clr", 32'(a_out), 32'd0);
        drive(1'b0, 1'b1, 5'd5, 1'b1, 1'b1);
        tick();
        check("prio_load_out",   32'(a_out),   32'd5);
        check("prio_load_carry", 32'(a_carry), 32'd0);
        drive(1'b0, 1'b1, 5'd31, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b1, 5'd31, 1'b1, 1'b1);
        tick();
        check("ld_at_max_a_out",   32'(a_out),   32'd31);
        check("ld_at_max_a_carry", 32'(a_carry), 32'd0);
        check("ld_at_max_c_carry", 32'(c_carry), 32'd0);
        drive(1'b1, 1'b0, 5'd0, 1'b1, 1'b0);
        tick();
        check("clr_at_zero_borrow", 32'(a_borrow), 32'd0);

        // Hold with E=0 while D toggles
        drive(1'b0, 1'b1, 5'd4, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b0, 5'd0, 1'b0, 1'(i % 2));
            tick();
            check($sformatf("hold_out_%0d", i),
                  {23'b0, a_out, a_carry, a_borrow, c_out[3:0]},
                  {23'b0, 5'd4, 1'b0, 1'b0, 4'd4});
        end

        // Continuous E with D toggling: +1/-1 alternation
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b0, 5'd0, 1'b1, 1'(i % 2 == 0));
            tick();
            check($sformatf("toggle_%0d", i), 32'(a_out),
                  (i % 2 == 0) ? 32'd5 : 32'd4);
        end

        // Random run against the model
        drive(1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        for (int k = 0; k < 3; k++) begin
            m_cnt[k]    = 0;
            m_carry[k]  = 1'b0;
            m_borrow[k] = 1'b0;
        end
        for (int i = 0; i < 10000; i++) begin
            logic       r_clr, r_load, r_e, r_d;
            logic [4:0] r_lv;
            r_clr  = ($urandom_range(0, 31) == 0);
            r_load = ($urandom_range(0, 15) == 0);
            r_e    = ($urandom_range(0, 3) != 0);
            r_d    = 1'($urandom_range(0, 1));
            r_lv   = 5'($urandom_range(0, 31));
            drive(r_clr, r_load, r_lv, r_e, r_d);
            for (int k = 0; k < 3; k++)
                model_step(k, r_clr, r_load, int'(r_lv), r_e, r_d);
            tick();
            check("rand_a", {23'b0, a_out, a_carry, a_borrow, a_max, a_zero},
                  model_pack(0));
            check("rand_b", {23'b0, b_out, b_carry, b_borrow, b_max, b_zero},
                  model_pack(1));
            check("rand_c", {23'b0, c_out, c_carry, c_borrow, c_max, c_zero},
                  model_pack(2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
